// File: rtl/conv_pkg.sv
// Shared helpers and FSM encodings for the multi-channel convolution engine.
package conv_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned cw(input int unsigned v);
        return (clog2(v) == 0) ? 1 : clog2(v);
    endfunction

    function automatic int unsigned acc_w(input int unsigned dw, input int unsigned n);
        return 2 * dw + clog2(n) + 1;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StEmit,
        StDone
    } state_e;

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate; preload restarts the sum from the sign-extended bias.
module conv_mac_unit
    import conv_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned ACC_W = 20
) (
    input  logic                    clk_en,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    preload,
    input  logic signed [DW-1:0]    bias,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    always_comb begin
        prod     = (2 * DW)'(a) * (2 * DW)'(b);
        prod_ext = {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};
        bias_ext = {{(ACC_W - DW){bias[DW-1]}}, bias};
        acc_d    = acc_q;
        if (en) begin
            acc_d = (preload ? bias_ext : acc_q) + prod_ext;
        end
    end

    always_ff @(posedge clk_en) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv_mc_engine.sv
// Multi-channel 2-D convolution, one MAC per cycle, valid/ready pixel output.
// Define CONV_RELU_EN to clamp negative output pixels to zero.
module conv_mc_engine
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned K_W    = 3,
    parameter int unsigned K_H    = 3,
    parameter int unsigned CIN    = 2,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned PAD    = 0,
    parameter int unsigned DW     = 8,
    localparam int unsigned RES_W = (IMG_W - K_W + 2 * PAD) / STRIDE + 1,
    localparam int unsigned RES_H = (IMG_H - K_H + 2 * PAD) / STRIDE + 1,
    localparam int unsigned N     = K_W * K_H * CIN,
    localparam int unsigned ACC_W = acc_w(DW, N),
    localparam int unsigned RW    = cw(RES_H),
    localparam int unsigned CLW   = cw(RES_W)
) (
    input  logic                          clk_en,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [CIN*IMG_H*IMG_W*DW-1:0] img,
    input  logic [CIN*K_H*K_W*DW-1:0]     weight,
    input  logic [DW-1:0]                 bias,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [ACC_W-1:0]       out_data,
    output logic [RW-1:0]                 out_row,
    output logic [CLW-1:0]                out_col,
    output logic                          done
);

    localparam int unsigned CW  = cw(CIN);
    localparam int unsigned KRW = cw(K_H);
    localparam int unsigned KCW = cw(K_W);

    state_e state_q, state_d;
    logic [CIN*IMG_H*IMG_W*DW-1:0] img_q;
    logic [CIN*K_H*K_W*DW-1:0]     weight_q;
    logic signed [DW-1:0]          bias_q;
    logic [CW-1:0]                 ch_q, ch_d;
    logic [KRW-1:0]                kr_q, kr_d;
    logic [KCW-1:0]                kc_q, kc_d;
    logic [RW-1:0]                 row_q, row_d;
    logic [CLW-1:0]                col_q, col_d;
    logic                          valid_q, valid_d;
    logic signed [ACC_W-1:0]       data_q, data_d;
    logic signed [ACC_W-1:0]       acc;
    logic signed [DW-1:0]          pix, wv;
    logic                          capture, mac_en, first_tap, last_pix;

    // Tap fetch: taps falling in the padding border read as zero.
    always_comb begin : tap_sel
        int iy, ix;
        iy  = int'(row_q) * int'(STRIDE) + int'(kr_q) - int'(PAD);
        ix  = int'(col_q) * int'(STRIDE) + int'(kc_q) - int'(PAD);
        pix = '0;
        if (iy >= 0 && iy < int'(IMG_H) && ix >= 0 && ix < int'(IMG_W)) begin
            pix = img_q[((int'(ch_q) * int'(IMG_H) + iy) * int'(IMG_W) + ix) * int'(DW) +: DW];
        end
        wv = weight_q[((int'(ch_q) * int'(K_H) + int'(kr_q)) * int'(K_W) + int'(kc_q))
                      * int'(DW) +: DW];
    end

    assign first_tap = (ch_q == '0) && (kr_q == '0) && (kc_q == '0);
    assign last_pix  = (row_q == RW'(RES_H - 1)) && (col_q == CLW'(RES_W - 1));
    assign capture   = (state_q == StIdle) && start;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        row_d   = row_q;
        col_d   = col_q;
        valid_d = valid_q;
        data_d  = data_q;
        mac_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StMac;
                    ch_d    = '0;
                    kr_d    = '0;
                    kc_d    = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StMac: begin
                mac_en = 1'b1;
                if (kc_q == KCW'(K_W - 1)) begin
                    kc_d = '0;
                    if (kr_q == KRW'(K_H - 1)) begin
                        kr_d = '0;
                        if (ch_q == CW'(CIN - 1)) begin
                            ch_d    = '0;
                            state_d = StEmit;
                        end else begin
                            ch_d = ch_q + CW'(1);
                        end
                    end else begin
                        kr_d = kr_q + KRW'(1);
                    end
                end else begin
                    kc_d = kc_q + KCW'(1);
                end
            end
            StEmit: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
`ifdef CONV_RELU_EN
                    data_d  = acc[ACC_W-1] ? '0 : acc;
`else
                    data_d  = acc;
`endif
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    if (last_pix) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StMac;
                        if (col_q == CLW'(RES_W - 1)) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CLW'(1);
                        end
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_en) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ch_q    <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            kr_q    <= kr_d;
            kc_q    <= kc_d;
            row_q   <= row_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Operand snapshot taken at start so the run is immune to input changes.
    always_ff @(posedge clk_en) begin
        if (capture) begin
            img_q    <= img;
            weight_q <= weight;
            bias_q   <= bias;
        end
    end

    conv_mac_unit #(
        .DW   (DW),
        .ACC_W(ACC_W)
    ) u_mac (
        .clk_en (clk_en),
        .rst_n  (rst_n),
        .en     (mac_en),
        .preload(first_tap),
        .bias   (bias_q),
        .a      (pix),
        .b      (wv),
        .acc    (acc)
    );

    assign busy      = (state_q == StMac) || (state_q == StEmit);
    assign done      = (state_q == StDone);
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;

endmodule
